wand_trace_capture: RTL and testbench

- Producer side of the 25-bit `ir_in` trace bitmap that the VGA display path consumes for the 5x5 box grid.
- Synchronises and qualifies the 25 raw IR sensor lines and accumulates hits into a sticky bitmap during a timed trace round.
- Drives the `get_ready` / `times_up` screen-select flags that the display path uses to switch screens.
- Sits between board GPIO and the VGA controller, in the `iVGA_CLK` domain.

---
 rtl/wand_trace_capture.sv | 205 ++++++++++++++++++++
 tb/tb_wand_trace_capture.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wand_trace_capture.sv
// IR wand trace capture: synchronises and qualifies the 25 box sensors and
// accumulates hits into a sticky bitmap during a timed get-ready/trace round.
module wand_trace_capture #(
    parameter int unsigned SAMPLE_DIV  = 25000,
    parameter int unsigned READY_TICKS = 3000,
    parameter int unsigned TRACE_TICKS = 10000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic [24:0] sensor_raw,
    input  logic        start,
    input  logic        clear,
    output logic [24:0] ir_out,
    output logic        get_ready,
    output logic        times_up,
    output logic        tracing,
    output logic        new_hit,
    output logic [4:0]  last_hit,
    output logic [4:0]  hit_count
);

    localparam int unsigned N_BOX = 25;
    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_TRACE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [N_BOX-1:0]   r_s1;
    logic [N_BOX-1:0]   r_s2;
    logic [N_BOX-1:0]   r_prev;
    logic [CNT_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_BOX-1:0]   r_ir;
    logic [IDX_W-1:0]   r_hit_count;
    logic [IDX_W-1:0]   r_last_hit;
    logic               r_new_hit;
    logic               r_get_ready;
    logic               r_tracing;
    logic               r_times_up;

    logic               w_tick;
    logic [N_BOX-1:0]   w_qual;
    logic [N_BOX-1:0]   w_newbits;
    logic [N_BOX-1:0]   w_ir_or;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N_BOX-1:0]   w_ir_nxt;
    logic [IDX_W-1:0]   w_hit_nxt;
    logic [IDX_W-1:0]   w_last_nxt;
    logic               w_new_hit_nxt;

    function automatic logic [IDX_W-1:0] popcount(input logic [N_BOX-1:0] v);
        logic [IDX_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(N_BOX); i++) begin
            c = c + IDX_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_BOX-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_BOX) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Free-running sample-tick divider; only reset touches it.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CNT_W'(1);
        end
    end

    assign w_tick = (r_div == CNT_W'(SAMPLE_DIV - 1));

    // Two-flop synchroniser plus previous-tick sample for glitch rejection.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1 <= sensor_raw;
            r_s2 <= r_s1;
            if (w_tick) r_prev <= r_s2;
        end
    end

    assign w_qual    = w_tick ? (r_s2 & r_prev) : '0;
    assign w_newbits = w_qual & ~r_ir;
    assign w_ir_or   = r_ir | w_newbits;

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ir_nxt      = r_ir;
        w_hit_nxt     = r_hit_count;
        w_last_nxt    = r_last_hit;
        w_new_hit_nxt = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_ir_nxt    = '0;
            w_hit_nxt   = '0;
            w_last_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_READY;
                        w_cnt_nxt   = '0;
                        w_ir_nxt    = '0;
                        w_hit_nxt   = '0;
                        w_last_nxt  = '0;
                    end
                end
                ST_READY: begin
                    if (w_tick) begin
                        if (r_cnt == CNT_W'(READY_TICKS - 1)) begin
                            w_state_nxt = ST_TRACE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_TRACE: begin
                    // Final-tick hits are merged before the exit to DONE.
                    if (w_tick) begin
                        w_ir_nxt  = w_ir_or;
                        w_hit_nxt = r_hit_count + popcount(w_newbits);
                        if (|w_newbits) begin
                            w_new_hit_nxt = 1'b1;
                            w_last_nxt    = lowest_idx(w_newbits);
                        end
                        if ((r_cnt == CNT_W'(TRACE_TICKS - 1)) || (&w_ir_or)) begin
                            w_state_nxt = ST_DONE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath and screen-select flags, flags decoded from the next state.
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            r_cnt       <= '0;
            r_ir        <= '0;
            r_hit_count <= '0;
            r_last_hit  <= '0;
            r_new_hit   <= 1'b0;
            r_get_ready <= 1'b0;
            r_tracing   <= 1'b0;
            r_times_up  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_ir        <= w_ir_nxt;
            r_hit_count <= w_hit_nxt;
            r_last_hit  <= w_last_nxt;
            r_new_hit   <= w_new_hit_nxt;
            r_get_ready <= (w_state_nxt == ST_READY);
            r_tracing   <= (w_state_nxt == ST_TRACE);
            r_times_up  <= (w_state_nxt == ST_DONE);
        end
    end

    assign ir_out    = r_ir;
    assign get_ready = r_get_ready;
    assign tracing   = r_tracing;
    assign times_up  = r_times_up;
    assign new_hit   = r_new_hit;
    assign last_hit  = r_last_hit;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_wand_trace_capture.sv
// Directed table-driven bench for wand_trace_capture with a short divider
// (4 clocks per tick), plus a few hand-written multi-cycle sequences.
module tb_wand_trace_capture;

    logic        clk;
    logic        rst_n;
    logic [24:0] sensor_raw;
    logic        start;
    logic        clear;
    logic [24:0] ir_out;
    logic        get_ready;
    logic        times_up;
    logic        tracing;
    logic        new_hit;
    logic [4:0]  last_hit;
    logic [4:0]  hit_count;

    int n_cmp;
    int n_err;
    int cyc;

    wand_trace_capture #(
        .SAMPLE_DIV (4),
        .READY_TICKS(3),
        .TRACE_TICKS(10),
        .CNT_W      (16)
    ) dut (
        .iVGA_CLK  (clk),
        .iRST_n    (rst_n),
        .sensor_raw(sensor_raw),
        .start     (start),
        .clear     (clear),
        .ir_out    (ir_out),
        .get_ready (get_ready),
        .times_up  (times_up),
        .tracing   (tracing),
        .new_hit   (new_hit),
        .last_hit  (last_hit),
        .hit_count (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        rst_n;
        logic [24:0] raw;
        logic        start;
        logic        clear;
        logic [1:0]  st;    // 0 idle, 1 ready, 2 trace, 3 done
        logic [24:0] ir;
        logic [4:0]  cnt;
        logic [4:0]  last;
        logic        nh;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int c, input logic r, input logic [24:0] raw,
                                input logic s, input logic cl, input logic [1:0] st,
                                input logic [24:0] ir, input logic [4:0] cnt,
                                input logic [4:0] last, input logic nh);
        vec_t v;
        v.cyc = c; v.rst_n = r; v.raw = raw; v.start = s; v.clear = cl;
        v.st = st; v.ir = ir; v.cnt = cnt; v.last = last; v.nh = nh;
        return v;
    endfunction

    function automatic logic [2:0] flags_of(input logic [1:0] st);
        case (st)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nh_pulses;
        int waited;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;

        // cyc k = k-th clock edge after the last reset edge; ticks fall on k%4==0.
        vq.push_back(mk(  0, 1, 25'h0,       0, 0, 0, 25'h0,       0,  0, 0));
        vq.push_back(mk(  1, 1, 25'h0,       1, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk(  5, 1, 25'h0,       0, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk( 11, 1, 25'h1000,    0, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk( 12, 1, 25'h1000,    0, 0, 2, 25'h0,       0,  0, 0));
        vq.push_back(mk( 16, 1, 25'h1000,    0, 0, 2, 25'h1000,    1, 12, 1));
        vq.push_back(mk( 17, 1, 25'h1000,    0, 0, 2, 25'h1000,    1, 12, 0));
        vq.push_back(mk( 20, 1, 25'h1008,    0, 0, 2, 25'h1000,    1, 12, 0));
        vq.push_back(mk( 24, 1, 25'h1000,    0, 0, 2, 25'h1000,    1, 12, 0));
        vq.push_back(mk( 25, 1, 25'h1000,    0, 0, 2, 25'h1000,    1, 12, 0));
        vq.push_back(mk( 32, 1, 25'h1080,    0, 0, 2, 25'h1080,    2,  7, 1));
        vq.push_back(mk( 33, 1, 25'h1080,    0, 0, 2, 25'h1080,    2,  7, 0));
        vq.push_back(mk( 36, 1, 25'h1080,    1, 0, 2, 25'h1080,    2,  7, 0));
        vq.push_back(mk( 51, 1, 25'h1080,    0, 0, 2, 25'h1080,    2,  7, 0));
        vq.push_back(mk( 52, 1, 25'h1080,    0, 0, 3, 25'h1080,    2,  7, 0));
        vq.push_back(mk( 56, 1, 25'h1080,    0, 0, 3, 25'h1080,    2,  7, 0));
        vq.push_back(mk( 57, 1, 25'h0,       1, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk( 67, 1, 25'h0,       0, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk( 68, 1, 25'h0,       0, 0, 2, 25'h0,       0,  0, 0));
        vq.push_back(mk( 73, 1, 25'h0,       0, 0, 2, 25'h0,       0,  0, 0));
        vq.push_back(mk( 80, 1, 25'h24,      0, 0, 2, 25'h24,      2,  2, 1));
        vq.push_back(mk( 81, 1, 25'h24,      0, 0, 2, 25'h24,      2,  2, 0));
        vq.push_back(mk(107, 1, 25'h24,      0, 0, 2, 25'h24,      2,  2, 0));
        vq.push_back(mk(108, 1, 25'h24,      0, 0, 3, 25'h24,      2,  2, 0));
        vq.push_back(mk(109, 1, 25'h0,       1, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk(125, 1, 25'h0,       0, 0, 2, 25'h0,       0,  0, 0));
        vq.push_back(mk(131, 1, 25'h1FFFFFF, 0, 0, 2, 25'h0,       0,  0, 0));
        vq.push_back(mk(132, 1, 25'h1FFFFFF, 0, 0, 3, 25'h1FFFFFF, 25, 0, 1));
        vq.push_back(mk(133, 1, 25'h100,     1, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk(147, 1, 25'h100,     0, 0, 2, 25'h0,       0,  0, 0));
        vq.push_back(mk(148, 1, 25'h100,     0, 0, 2, 25'h100,     1,  8, 1));
        vq.push_back(mk(149, 1, 25'h100,     1, 1, 0, 25'h0,       0,  0, 0));
        vq.push_back(mk(150, 1, 25'h100,     1, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk(153, 1, 25'h100,     0, 0, 1, 25'h0,       0,  0, 0));
        vq.push_back(mk(154, 0, 25'h100,     0, 0, 0, 25'h0,       0,  0, 0));
        vq.push_back(mk(158, 1, 25'h100,     0, 0, 0, 25'h0,       0,  0, 0));

        rst_n      = 1'b0;
        sensor_raw = '0;
        start      = 1'b0;
        clear      = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            rst_n      = vq[i].rst_n;
            sensor_raw = vq[i].raw;
            start      = vq[i].start;
            clear      = vq[i].clear;
            while (cyc < vq[i].cyc) clk1();
            check($sformatf("v%0d_c%0d flags{tu,tr,gr}", i, vq[i].cyc),
                  32'({times_up, tracing, get_ready}), 32'(flags_of(vq[i].st)));
            check($sformatf("v%0d_c%0d ir_out", i, vq[i].cyc), 32'(ir_out), 32'(vq[i].ir));
            check($sformatf("v%0d_c%0d hit_count", i, vq[i].cyc), 32'(hit_count), 32'(vq[i].cnt));
            check($sformatf("v%0d_c%0d last_hit", i, vq[i].cyc), 32'(last_hit), 32'(vq[i].last));
            check($sformatf("v%0d_c%0d new_hit", i, vq[i].cyc), 32'(new_hit), 32'(vq[i].nh));
        end

        // New round from IDLE with arbitrary divider phase: wait for TRACE.
        sensor_raw = '0;
        start      = 1'b1;
        clk1();
        start  = 1'b0;
        waited = 0;
        while (!tracing && waited < 40) begin
            clk1();
            waited++;
        end
        check("seq_wait_tracing", 32'(tracing), 32'd1);

        // Full bitmap mid-trace: exactly one new_hit pulse, early DONE.
        sensor_raw = 25'h1FFFFFF;
        nh_pulses  = 0;
        waited     = 0;
        while (!times_up && waited < 60) begin
            clk1();
            waited++;
            if (new_hit) nh_pulses++;
        end
        check("seq_full_times_up", 32'(times_up), 32'd1);
        check("seq_full_new_hit_pulses", 32'(nh_pulses), 32'd1);
        check("seq_full_hit_count", 32'(hit_count), 32'd25);
        check("seq_full_ir_out", 32'(ir_out), 32'h1FFFFFF);
        check("seq_full_early", 32'(waited < 40), 32'd1);

        // DONE holds the bitmap while sensors drop.
        sensor_raw = '0;
        repeat (10) clk1();
        check("seq_done_hold_ir", 32'(ir_out), 32'h1FFFFFF);
        check("seq_done_hold_flag", 32'({times_up, tracing, get_ready}), 32'b100);

        // start together with clear in DONE: clear wins.
        start = 1'b1;
        clear = 1'b1;
        clk1();
        start = 1'b0;
        clear = 1'b0;
        check("seq_clr_start_flags", 32'({times_up, tracing, get_ready}), 32'b000);
        check("seq_clr_start_ir", 32'(ir_out), 32'h0);
        check("seq_clr_start_cnt", 32'(hit_count), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
